// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the control decoder and
// the execute unit, plus the execute FSM state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SLL  = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier datapath: one partial product per step, fixed WIDTH
// steps. acc presents the accumulator including the current step's addend.
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             last
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt;

    // Exposing the post-add value lets the top capture the final product on
    // the last step edge without an extra cycle.
    assign acc  = acc_q + (mplier[0] ? mcand : '0);
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc_q  <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc_q  <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc_q  <= acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle EX unit: single-cycle logic/arith/shift ops plus a fixed
// 32-step shift-add MUL, with valid/ready handshakes on both sides.
module alu_exec_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    state_t           state;
    state_t           state_next;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic             single_done;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] single_res;

    function automatic logic [WIDTH-1:0] single_op(
        input logic [2:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic [CNT_W-1:0]        shamt;
        logic [WIDTH-1:0]        res;
        sa    = a;
        shamt = b[CNT_W-1:0];
        case (ctrl)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << shamt;
            ALU_SRAI: res = sa >>> shamt;
            default:  res = '0;
        endcase
        return res;
    endfunction

    assign single_res = single_op(ALUCtrl_i, data1_i, data2_i);

    mul_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul_iter (
        .clk  (clk_i),
        .rst_n(rst_i),
        .load (mul_load),
        .step (mul_step),
        .a    (data1_i),
        .b    (data2_i),
        .acc  (mul_acc),
        .last (mul_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        single_done = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        mul_load   = 1'b1;
                        state_next = MUL;
                    end else begin
                        single_done = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and zero flag only change when a new result is produced, so
    // they stay stable through DONE backpressure and between operations.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            data_o <= '0;
            zero_o <= 1'b1;
        end else if (single_done) begin
            data_o <= single_res;
            zero_o <= (single_res == '0);
        end else if (mul_step && mul_last) begin
            data_o <= mul_acc;
            zero_o <= (mul_acc == '0);
        end
    end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
- Multi-cycle execute unit. Consumes the 3-bit ALU control code produced by the ALU control decoder, plus two 32-bit operands, and returns a 32-bit result and a zero flag.
- Single-cycle ops (AND/OR/XOR/SLL/SRAI/ADD/SUB) complete in one cycle. MUL runs as a 32-iteration shift-add sequence.
- Sits in EX between the ID/EX operand registers and the EX/MEM register. Uses valid/ready handshakes on both sides so the hazard unit can stall on MUL.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous active-low reset
- in_valid_i  input  1  operands and control valid
- in_ready_o  output  1  unit can accept an operation
- ALUCtrl_i  input  3  operation code (encoding in Behaviour)
- data1_i  input  WIDTH  operand A (rs1)
- data2_i  input  WIDTH  operand B (rs2 or immediate)
- out_valid_o  output  1  result available
- out_ready_i  input  1  consumer accepts result
- data_o  output  WIDTH  result
- zero_o  output  1  data_o == 0

Behaviour:
- Reset:
  - rst_i low at a rising edge forces state IDLE, iteration counter 0, and all internal registers 0.
  - Reset values: in_ready_o=1, out_valid_o=0, data_o=0, zero_o=1.
  - Reset mid-MUL discards the operation; no result is ever produced for it.
- ALUCtrl encoding:
  - 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 SLL, 111 SRAI.
  - SLL and SRAI use data2_i[4:0] as the shift amount. SRAI is an arithmetic right shift.
  - ADD, SUB and MUL wrap modulo 2^WIDTH. No overflow flag.
  - MUL returns the low WIDTH bits of the product.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, capture ALUCtrl_i, data1_i and data2_i.
  - Non-MUL op: compute result, register it into data_o, go to DONE.
  - MUL: load multiplicand=data1_i, multiplier=data2_i, acc=0, cnt=0, go to MUL.
- MUL:
  - in_ready_o=0.
  - Each cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - Exactly WIDTH cycles. On the edge where cnt==WIDTH-1, the final acc is written to data_o and the state goes to DONE.
  - No early exit on a zero multiplier; latency is fixed.
- DONE:
  - out_valid_o=1, in_ready_o=0.
  - data_o and zero_o are held stable until out_ready_i=1.
  - On the edge with out_ready_i=1, go to IDLE and drop out_valid_o.
- Latency, with accept at edge N:
  - Single-cycle op: out_valid_o high in the cycle after edge N.
  - MUL: out_valid_o high after edge N+32, i.e. 33 cycles after accept.
- Throughput: at most one op per 2 cycles. A new op is not accepted in the same cycle a result is consumed.
- in_valid_i while in_ready_o=0 is ignored. The upstream stage must hold it.
- zero_o is registered alongside data_o and is only meaningful while out_valid_o=1. Between results it holds its last value.
- data_o holds its last value in IDLE and MUL.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUCtrl localparams (ALU_AND … ALU_SRAI), shared with the control decoder;
  - the state encoding (IDLE=2'd0, MUL=2'd1, DONE=2'd2);
  - the WIDTH default.
- One sub-module, mul_iter: the shift-add datapath.
  - Inputs: load, step, a, b.
  - Outputs: acc, last (cnt==WIDTH-1).
  - The top keeps the FSM, the handshake and the single-cycle op mux.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles → in_ready_o=1, out_valid_o=0, data_o=0, zero_o=1.
- ADD/SUB: ADD 7+5 → data_o=12 one cycle after accept. SUB 5-5 → data_o=0, zero_o=1. SUB 0-1 → 0xFFFFFFFF.
- Shifts/logic:
  - SRAI 0x80000000 by 4 → 0xF8000000.
  - SLL 1 by 31 → 0x80000000.
  - XOR 0xFFFF0000^0x0F0F0F0F → 0xF0F00F0F.
- MUL: 0x12345678×0x9 → 0xA3D70A38 exactly 33 cycles after accept, in_ready_o=0 throughout. (-3)×7 → 0xFFFFFFEB.
- Backpressure: out_ready_i=0 for 5 cycles after result → data_o stable, out_valid_o=1; new in_valid_i ignored; after out_ready_i=1, IDLE next cycle.
- Reset mid-MUL: rst_i=0 at iteration 10 → IDLE, out_valid_o never rises for that op; next ADD 2+2 → data_o=4.
